serial_parity_unit: RTL and testbench
=====================================

Name: serial_parity_unit

Overview:
Bit-serial parity generator that sits upstream of the 2-input XOR cell. It folds one data bit per clock into a running XOR accumulator. It accepts a word over a valid/ready input handshake, shifts it LSB-first through the accumulator for DATA_W cycles, then presents the parity bit and the original word on a valid/ready output handshake. It is a teaching-scale datapath: one XOR per cycle plus a small control FSM.

Parameters:
DATA_W, 8, word width in bits; legal range 2..32.
ODD, 0, 0 = even parity (accumulator seeded 0); 1 = odd parity (accumulator seeded 1).

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  upstream word available.
in_ready  output  1  block can accept a word (high only in IDLE).
in_data  input  DATA_W  word to be checked.
out_valid  output  1  parity result available (high only in DONE).
out_ready  input  1  downstream consumes result.
out_parity  output  1  accumulated parity bit.
out_data  output  DATA_W  copy of the accepted word, held stable while out_valid.
busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (async, any time, including mid-SHIFT or in DONE): state=IDLE, in_ready=1, out_valid=0, out_parity=0, out_data=0, busy=0, shift register=0, counter=0. The in-flight word is discarded. Outputs go to reset values immediately, not at the next edge.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On an edge with in_valid=1:
  - load the shift register and out_data with in_data
  - acc<=ODD
  - cnt<=0
  - go to SHIFT.
  With in_valid=0, stay in IDLE.
- SHIFT: in_ready=0, out_valid=0. Every edge:
  - acc<=acc^sh[0]
  - sh<=sh>>1 (zero fill)
  - cnt<=cnt+1
  On the edge where cnt==DATA_W-1 the update still happens and the state goes to DONE. Exactly DATA_W shift edges occur.
- DONE: out_valid=1, out_parity=acc. out_data and out_parity are stable until the handshake completes. On an edge with out_ready=1, go to IDLE; otherwise hold indefinitely.
- Latency: the accept edge is edge 0. out_valid rises after edge DATA_W. Minimum spacing between accepts is DATA_W+2 edges (accept, DATA_W shifts, handshake edge, then IDLE).
- in_valid/in_data in SHIFT or DONE are ignored. Upstream must hold in_valid until it sees in_ready.
- out_ready in IDLE or SHIFT has no effect.
- Counter width is max(1,$clog2(DATA_W)). The counter never wraps past DATA_W-1.
- In IDLE, out_data and out_parity keep their last values. out_valid is the only qualifier.
- Parity result: out_parity = ODD ^ (XOR reduction of the accepted word).

Test Plan:
1. DATA_W=8, ODD=0, in_data=0xA5, out_ready=1 -> out_valid rises 8 edges after accept; out_parity=0, out_data=0xA5; IDLE again one edge later.
2. DATA_W=8, ODD=0, in_data=0x01, then 0xFF, back-to-back with in_valid held high -> parities 1 then 0; second accept occurs exactly 10 edges after the first.
3. ODD=1, in_data=0x00 -> out_parity=1. Then in_data=0x80 -> out_parity=0.
4. Backpressure: in_data=0x07, out_ready=0 for 5 cycles after out_valid -> out_valid, out_parity=1 and out_data=0x07 held; in_ready=0 throughout; a new in_valid word (0x55) is not accepted until after the handshake.
5. Reset mid-SHIFT: assert rst asynchronously 3 edges after accepting 0x3C -> outputs immediately at reset values; after release, in_ready=1 and the next word 0x10 yields out_parity=1 with no residue from 0x3C.
6. Randomized sweep, 200 words, random out_ready stalls -> every out_parity equals ODD^(XOR reduction of in_data), out_data matches, in order.

Source files
------------

// File: rtl/serial_parity_unit.sv
// Bit-serial parity generator: accepts a word, folds it LSB-first into an XOR
// accumulator over DATA_W cycles, then offers parity and the word downstream.
module serial_parity_unit #(
    parameter int DATA_W = 8,
    parameter bit ODD    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_parity,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_sh;
    logic [DATA_W-1:0] r_data;
    logic              r_acc;
    logic [CW-1:0]     r_cnt;
    logic              w_accept;
    logic              w_last;

    assign w_last = (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        w_accept  = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Counter saturates at DATA_W-1 so it never wraps on the final shift edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh   <= '0;
            r_data <= '0;
            r_acc  <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_sh   <= in_data;
            r_data <= in_data;
            r_acc  <= ODD;
            r_cnt  <= '0;
        end else if (r_state == SHIFT) begin
            r_acc <= r_acc ^ r_sh[0];
            r_sh  <= r_sh >> 1;
            r_cnt <= w_last ? r_cnt : r_cnt + 1'b1;
        end
    end

    assign out_parity = r_acc;
    assign out_data   = r_data;

endmodule

// File: tb/tb_serial_parity_unit.sv
// Bench for serial_parity_unit: even and odd instances share stimulus; results
// are scored against a counting parity model fed by an in-order queue.
module tb_serial_parity_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;

    logic         rdy0, ov0, par0, busy0;
    logic         rdy1, ov1, par1, busy1;
    logic [W-1:0] od0, od1;

    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           n_recv = 0;
    logic [W-1:0] exp_q[$];
    int           acc_cyc[$];
    logic [W-1:0] mw;

    serial_parity_unit #(.DATA_W(W), .ODD(1'b0)) u_even (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_parity(par0), .out_data(od0), .busy(busy0)
    );

    serial_parity_unit #(.DATA_W(W), .ODD(1'b1)) u_odd (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_parity(par1), .out_data(od1), .busy(busy1)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic ref_par(input logic [W-1:0] w, input logic odd);
        int ones = 0;
        for (int i = 0; i < W; i++) if (w[i]) ones++;
        return odd ^ ((ones % 2) == 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accept enqueues, every output handshake is checked in order.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (in_valid && rdy0) begin
                exp_q.push_back(in_data);
                acc_cyc.push_back(cyc);
            end
            if (ov0 && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_unexpected: result 0x%0h with no pending word", od0);
                end else begin
                    mw = exp_q.pop_front();
                    chk("sb_par_even", 32'(par0), 32'(ref_par(mw, 1'b0)));
                    chk("sb_par_odd", 32'(par1), 32'(ref_par(mw, 1'b1)));
                    chk("sb_data_even", 32'(od0), 32'(mw));
                    chk("sb_data_odd", 32'(od1), 32'(mw));
                    chk("sb_valid_odd", 32'(ov1), 32'd1);
                    n_recv++;
                end
            end
        end
    end

    always @(posedge rst) exp_q.delete();

    task automatic do_word(input logic [W-1:0] d, input int stall, input logic pe, input logic po);
        int n;
        chk("idle_in_ready", 32'(rdy0), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = W'($urandom);
        chk("shift_busy", 32'(busy0), 32'd1);
        chk("shift_in_ready", 32'(rdy0), 32'd0);
        n = 0;
        while (!ov0 && n < 40) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'(W));
        chk("done_par_even", 32'(par0), 32'(pe));
        chk("done_par_odd", 32'(par1), 32'(po));
        chk("done_data", 32'(od0), 32'(d));
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("stall_valid", 32'(ov0), 32'd1);
            chk("stall_par", 32'(par0), 32'(pe));
            chk("stall_data", 32'(od0), 32'(d));
            chk("stall_in_ready", 32'(rdy0), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_valid", 32'(ov0), 32'd0);
        chk("post_in_ready", 32'(rdy0), 32'd1);
        chk("post_busy", 32'(busy0), 32'd0);
        chk("post_data_kept", 32'(od0), 32'(d));
    endtask

    typedef struct {
        logic [W-1:0] d;
        int           stall;
        logic         pe;
        logic         po;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n;
        int sent;
        int guard;
        int r0;
        logic acc;

        vecs[0] = '{8'hA5, 0, 1'b0, 1'b1};
        vecs[1] = '{8'h00, 0, 1'b0, 1'b1};
        vecs[2] = '{8'h80, 1, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 2, 1'b0, 1'b1};
        vecs[4] = '{8'h01, 0, 1'b1, 1'b0};
        vecs[5] = '{8'h3C, 3, 1'b0, 1'b1};
        vecs[6] = '{8'h07, 0, 1'b1, 1'b0};

        #1 rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(rdy0), 32'd1);
        chk("rst_out_valid", 32'(ov0), 32'd0);
        chk("rst_parity", 32'(par0), 32'd0);
        chk("rst_parity_odd", 32'(par1), 32'd0);
        chk("rst_data", 32'(od0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) do_word(vecs[i].d, vecs[i].stall, vecs[i].pe, vecs[i].po);

        // Back-to-back accepts with in_valid held high
        acc_cyc.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h01;
        tick();
        in_data = 8'hFF;
        n = 0;
        while (!ov0 && n < 40) begin tick(); n++; end
        chk("b2b_par1", 32'(par0), 32'd1);
        n = 0;
        while (acc_cyc.size() < 2 && n < 40) begin tick(); n++; end
        in_valid = 1'b0;
        chk("b2b_accepts", 32'(acc_cyc.size()), 32'd2);
        if (acc_cyc.size() >= 2) chk("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'(W + 2));
        n = 0;
        while (!ov0 && n < 40) begin tick(); n++; end
        chk("b2b_par2", 32'(par0), 32'd0);
        tick();
        out_ready = 1'b0;
        chk("b2b_idle", 32'(rdy0), 32'd1);

        // Backpressure with a competing word held on the input
        acc_cyc.delete();
        in_valid = 1'b1;
        in_data  = 8'h07;
        tick();
        in_data = 8'h55;
        n = 0;
        while (!ov0 && n < 40) begin tick(); n++; end
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("bp_valid", 32'(ov0), 32'd1);
            chk("bp_par", 32'(par0), 32'd1);
            chk("bp_data", 32'(od0), 32'h07);
            chk("bp_in_ready", 32'(rdy0), 32'd0);
        end
        chk("bp_not_accepted", 32'(acc_cyc.size()), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle", 32'(rdy0), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_accepts", 32'(acc_cyc.size()), 32'd2);
        if (acc_cyc.size() >= 2) chk("bp_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'(W + 7));
        n = 0;
        while (!ov0 && n < 40) begin tick(); n++; end
        chk("bp_par55", 32'(par0), 32'd0);
        chk("bp_data55", 32'(od0), 32'h55);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset in the middle of a shift
        in_valid = 1'b1;
        in_data  = 8'h3C;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_in_ready", 32'(rdy0), 32'd1);
        chk("arst_valid", 32'(ov0), 32'd0);
        chk("arst_par", 32'(par0), 32'd0);
        chk("arst_data", 32'(od0), 32'd0);
        chk("arst_busy", 32'(busy0), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        do_word(8'h10, 0, 1'b1, 1'b0);

        // Randomized sweep with downstream stalls
        r0    = n_recv;
        sent  = 0;
        guard = 0;
        while ((sent < 200 || (n_recv - r0) < 200) && guard < 20000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < 200 && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b1;
                in_data  = W'($urandom);
            end
            acc = in_valid && rdy0;
            tick();
            guard++;
            if (acc) begin
                in_valid = 1'b0;
                sent++;
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("sweep_sent", 32'(sent), 32'd200);
        chk("sweep_received", 32'(n_recv - r0), 32'd200);
        chk("sweep_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
